fetch_unit: RTL and testbench

// - Instruction-fetch front end feeding the datapath: generates PC, issues word reads to instruction

---
 rtl/fetch_unit_if.sv | 39 +++
 rtl/fetch_unit.sv | 172 +++++++++++++++++
 tb/tb_fetch_unit.sv | 265 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_unit_if.sv
// Bundles the instruction-memory request/response channel, the decode-stage
// handshake and the redirect inputs of fetch_unit.
interface fetch_unit_if #(
   parameter int XLEN = 32
);
   logic            imem_req_valid;
   logic            imem_req_ready;
   logic [XLEN-1:0] imem_req_addr;
   logic            imem_rsp_valid;
   logic [31:0]     imem_rsp_data;
   logic            imem_rsp_err;
   logic            inst_valid;
   logic            inst_ready;
   logic [31:0]     inst;
   logic [XLEN-1:0] inst_pc;
   logic            inst_fault;
   logic            redirect;
   logic [XLEN-1:0] redirect_pc;

   // Fetch unit side.
   modport master (
      output imem_req_valid, imem_req_addr,
      input  imem_req_ready,
      input  imem_rsp_valid, imem_rsp_data, imem_rsp_err,
      output inst_valid, inst, inst_pc, inst_fault,
      input  inst_ready,
      input  redirect, redirect_pc
   );

   // Memory / datapath side.
   modport slave (
      input  imem_req_valid, imem_req_addr,
      output imem_req_ready,
      output imem_rsp_valid, imem_rsp_data, imem_rsp_err,
      input  inst_valid, inst, inst_pc, inst_fault,
      output inst_ready,
      output redirect, redirect_pc
   );
endinterface

// File: rtl/fetch_unit.sv
// Instruction-fetch front end: PC generation, imem request issue, in-order response
// tracking, prefetch FIFO and redirect flush. FETCH_PERF_EN adds perf counters.
module fetch_unit #(
   parameter int              XLEN       = 32,
   parameter logic [XLEN-1:0] RESET_PC   = '0,
   parameter int              FIFO_DEPTH = 4
) (
   input  logic         clk,
   input  logic         rst,
   fetch_unit_if.master bus
`ifdef FETCH_PERF_EN
   ,
   output logic [31:0]  perf_fetched,
   output logic [31:0]  perf_discarded,
   output logic [31:0]  perf_stall
`endif
);

   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int CW = PW + 1;
   localparam int IW = CW + 1;

   typedef struct packed {
      logic [31:0]     data;
      logic [XLEN-1:0] pc;
      logic            fault;
   } fifo_entry_t;

   logic [XLEN-1:0] pc_q, pc_d;
   logic [CW-1:0]   outstanding_q, outstanding_d;
   logic [CW-1:0]   discard_q, discard_d;
   logic [CW-1:0]   count_q, count_d;
   logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
   logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]   pcq_rd_q, pcq_rd_d;
   logic [PW-1:0]   pcq_wr_q, pcq_wr_d;

   fifo_entry_t     fifo_mem [FIFO_DEPTH];
   logic [XLEN-1:0] pcq_mem  [FIFO_DEPTH];

   fifo_entry_t     head;
   logic [IW-1:0]   inflight;
   logic [XLEN-1:0] redirect_target;
   logic            req_valid;
   logic            req_fire;
   logic            rsp_take;
   logic            rsp_drop;
   logic            push;
   logic            pop;
   logic            head_valid;

   // NOTE: every signal gets a default at the top of the block so no path leaves
   // one unassigned, which would otherwise infer a latch.
   always_comb begin
      redirect_target = bus.redirect_pc & ~XLEN'(3);
      head            = fifo_mem[rd_ptr_q];
      head_valid      = !rst && (count_q != '0);

      // Outstanding requests plus buffered words never exceed the FIFO depth, so
      // every response is guaranteed a slot when it arrives.
      inflight  = {1'b0, outstanding_q} + {1'b0, count_q};
      req_valid = !rst && !bus.redirect && (inflight < IW'(FIFO_DEPTH));
      req_fire  = req_valid && bus.imem_req_ready;

      rsp_take = bus.imem_rsp_valid && (outstanding_q != '0);
      rsp_drop = rsp_take && (bus.redirect || (discard_q != '0));
      push     = rsp_take && !rsp_drop;
      pop      = head_valid && bus.inst_ready && !bus.redirect;

      pc_d          = pc_q;
      outstanding_d = outstanding_q + CW'(req_fire) - CW'(rsp_take);
      discard_d     = discard_q;
      count_d       = count_q;
      rd_ptr_d      = rd_ptr_q;
      wr_ptr_d      = wr_ptr_q;
      pcq_wr_d      = pcq_wr_q + PW'(req_fire);
      pcq_rd_d      = pcq_rd_q + PW'(rsp_take);

      if (bus.redirect) begin
         // Everything still in flight after this cycle belongs to the old path;
         // this already covers any discard count carried over from earlier.
         pc_d      = redirect_target;
         discard_d = outstanding_q - CW'(rsp_take);
         count_d   = '0;
         rd_ptr_d  = '0;
         wr_ptr_d  = '0;
      end else begin
         if (req_fire) begin
            pc_d = pc_q + XLEN'(4);
         end
         if (rsp_drop) begin
            discard_d = discard_q - CW'(1);
         end
         count_d  = count_q + CW'(push) - CW'(pop);
         rd_ptr_d = rd_ptr_q + PW'(pop);
         wr_ptr_d = wr_ptr_q + PW'(push);
      end
   end

   // NOTE: state registers use non-blocking assignments so every flop samples
   // the values computed before this edge, independent of statement order.
   always_ff @(posedge clk) begin
      if (rst) begin
         pc_q          <= RESET_PC & ~XLEN'(3);
         outstanding_q <= '0;
         discard_q     <= '0;
         count_q       <= '0;
         rd_ptr_q      <= '0;
         wr_ptr_q      <= '0;
         pcq_rd_q      <= '0;
         pcq_wr_q      <= '0;
      end else begin
         pc_q          <= pc_d;
         outstanding_q <= outstanding_d;
         discard_q     <= discard_d;
         count_q       <= count_d;
         rd_ptr_q      <= rd_ptr_d;
         wr_ptr_q      <= wr_ptr_d;
         pcq_rd_q      <= pcq_rd_d;
         pcq_wr_q      <= pcq_wr_d;
      end
   end

   // NOTE: the storage arrays are deliberately not reset; the pointers and counts
   // are, and an entry is only ever read after it has been written.
   always_ff @(posedge clk) begin
      if (push) begin
         fifo_mem[wr_ptr_q] <= '{data:  bus.imem_rsp_data,
                                 pc:    pcq_mem[pcq_rd_q],
                                 fault: bus.imem_rsp_err};
      end
      if (req_fire) begin
         pcq_mem[pcq_wr_q] <= pc_q;
      end
   end

   assign bus.imem_req_valid = req_valid;
   assign bus.imem_req_addr  = pc_q;
   assign bus.inst_valid     = head_valid;
   assign bus.inst           = head_valid ? head.data  : '0;
   assign bus.inst_pc        = head_valid ? head.pc    : '0;
   assign bus.inst_fault     = head_valid ? head.fault : 1'b0;

`ifdef FETCH_PERF_EN
   logic [31:0] perf_fetched_q, perf_fetched_d;
   logic [31:0] perf_discarded_q, perf_discarded_d;
   logic [31:0] perf_stall_q, perf_stall_d;

   always_comb begin
      perf_fetched_d   = perf_fetched_q + 32'(push);
      perf_discarded_d = perf_discarded_q + 32'(rsp_drop);
      perf_stall_d     = perf_stall_q + 32'(req_valid && !bus.imem_req_ready);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         perf_fetched_q   <= '0;
         perf_discarded_q <= '0;
         perf_stall_q     <= '0;
      end else begin
         perf_fetched_q   <= perf_fetched_d;
         perf_discarded_q <= perf_discarded_d;
         perf_stall_q     <= perf_stall_d;
      end
   end

   assign perf_fetched   = perf_fetched_q;
   assign perf_discarded = perf_discarded_q;
   assign perf_stall     = perf_stall_q;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: in-order memory model with programmable
// latency, and a scoreboard that expects a sequential PC stream restarted by redirects.
module tb_fetch_unit;
   localparam int XLEN  = 32;
   localparam int DEPTH = 4;

   typedef struct {
      logic [31:0] addr;
      int          due;
   } mem_req_t;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   fetch_unit_if #(.XLEN(XLEN)) bus ();

`ifdef FETCH_PERF_EN
   logic [31:0] perf_fetched;
   logic [31:0] perf_discarded;
   logic [31:0] perf_stall;
`endif

   fetch_unit #(
      .XLEN       (XLEN),
      .RESET_PC   (32'h0),
      .FIFO_DEPTH (DEPTH)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
`ifdef FETCH_PERF_EN
      ,
      .perf_fetched   (perf_fetched),
      .perf_discarded (perf_discarded),
      .perf_stall     (perf_stall)
`endif
   );

   int          checks = 0;
   int          errors = 0;
   int          cyc;
   int          lat;
   int          first_valid_cyc;
   int          n_accepts;
   int          n_faults;
   logic [31:0] exp_pc;
   logic [31:0] err_addr;
   mem_req_t    memq[$];
   logic [31:0] fire_log[$];

   function automatic logic [31:0] word_at(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   // One clock cycle: sample at mid-cycle, then update the memory model after the edge.
   task automatic cycle();
      mem_req_t r;
      #1;
      if (!rst && bus.imem_req_valid && bus.imem_req_ready) begin
         memq.push_back('{addr: bus.imem_req_addr, due: cyc + lat});
         fire_log.push_back(bus.imem_req_addr);
      end
      if (!rst && bus.inst_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
      if (!rst && bus.redirect) begin
         exp_pc = bus.redirect_pc & ~32'h3;
      end else if (!rst && bus.inst_valid && bus.inst_ready) begin
         check("inst_pc", bus.inst_pc, exp_pc);
         check("inst_word", bus.inst, word_at(exp_pc));
         check("inst_fault", 32'(bus.inst_fault), 32'(exp_pc == err_addr));
         if (bus.inst_fault) n_faults++;
         exp_pc += 32'd4;
         n_accepts++;
      end
      @(posedge clk);
      #1;
      cyc++;
      if (rst) memq.delete();
      bus.imem_rsp_valid = 1'b0;
      bus.imem_rsp_data  = '0;
      bus.imem_rsp_err   = 1'b0;
      if (memq.size() > 0 && memq[0].due <= cyc) begin
         r = memq.pop_front();
         bus.imem_rsp_valid = 1'b1;
         bus.imem_rsp_data  = word_at(r.addr);
         bus.imem_rsp_err   = (r.addr == err_addr);
      end
      @(negedge clk);
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) cycle();
   endtask

   task automatic run_accepts(input string tag, input int target, input int budget);
      for (int i = 0; i < budget && n_accepts < target; i++) cycle();
      check(tag, 32'(n_accepts >= target), 32'd1);
   endtask

   task automatic do_reset();
      rst                = 1'b1;
      bus.redirect       = 1'b0;
      bus.redirect_pc    = '0;
      bus.inst_ready     = 1'b0;
      bus.imem_req_ready = 1'b1;
      cycle();
      cycle();
      rst             = 1'b0;
      cyc             = 0;
      exp_pc          = 32'h0;
      first_valid_cyc = -1;
      n_accepts       = 0;
      n_faults        = 0;
      fire_log.delete();
      memq.delete();
   endtask

   initial begin
      #200000;
      $fatal(1, "FAIL watchdog: simulation did not finish in time");
   end

   initial begin
      int fb;
      int acc;

      rst                = 1'b1;
      lat                = 1;
      cyc                = 0;
      err_addr           = 32'h1;
      exp_pc             = 32'h0;
      first_valid_cyc    = -1;
      n_accepts          = 0;
      n_faults           = 0;
      bus.imem_req_ready = 1'b1;
      bus.imem_rsp_valid = 1'b0;
      bus.imem_rsp_data  = '0;
      bus.imem_rsp_err   = 1'b0;
      bus.inst_ready     = 1'b0;
      bus.redirect       = 1'b0;
      bus.redirect_pc    = '0;

      // Outputs while reset is held.
      cycle();
      cycle();
      check("rst_req_valid", 32'(bus.imem_req_valid), 32'd0);
      check("rst_inst_valid", 32'(bus.inst_valid), 32'd0);
      check("rst_inst", bus.inst, 32'h0);
      check("rst_inst_pc", bus.inst_pc, 32'h0);
      check("rst_inst_fault", 32'(bus.inst_fault), 32'd0);

      // Single-cycle memory, consumer always ready.
      lat = 1;
      do_reset();
      bus.inst_ready = 1'b1;
      run(12);
      check("first_valid_cycle", 32'(first_valid_cyc), 32'd2);
      check("seq_addr0", fire_log[0], 32'h0);
      check("seq_addr1", fire_log[1], 32'h4);
      check("seq_addr2", fire_log[2], 32'h8);
      check("seq_addr3", fire_log[3], 32'hC);
      check("seq_accepts", 32'(n_accepts >= 4), 32'd1);

      // Consumer stalled: issue stops at the FIFO depth, then drains in order.
      do_reset();
      bus.inst_ready = 1'b0;
      run(20);
      check("stall_fires", 32'(fire_log.size()), 32'(DEPTH));
      check("stall_req_valid", 32'(bus.imem_req_valid), 32'd0);
      check("stall_inst_valid", 32'(bus.inst_valid), 32'd1);
      bus.inst_ready = 1'b1;
      run_accepts("drain_accepts", 2 * DEPTH, 40);

      // Latency 3, redirect with two requests in flight.
      lat = 3;
      do_reset();
      bus.inst_ready = 1'b1;
      for (int i = 0; i < 10 && memq.size() < 2; i++) cycle();
      check("redir_outstanding", 32'(memq.size()), 32'd2);
      fb = fire_log.size();
      bus.redirect    = 1'b1;
      bus.redirect_pc = 32'h103;
      #1;
      check("redir_req_valid", 32'(bus.imem_req_valid), 32'd0);
      cycle();
      bus.redirect = 1'b0;
      check("redir_fifo_empty", 32'(bus.inst_valid), 32'd0);
      acc = n_accepts;
      run_accepts("redir_accepts", acc + 3, 30);
      check("redir_addr", (fire_log.size() > fb) ? fire_log[fb] : 32'hDEAD_BEEF, 32'h100);
`ifdef FETCH_PERF_EN
      check("perf_discarded", perf_discarded, 32'd2);
`endif

      // Memory not ready: request held stable.
      lat = 1;
      do_reset();
      bus.imem_req_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         #1;
         check("hold_valid", 32'(bus.imem_req_valid), 32'd1);
         check("hold_addr", bus.imem_req_addr, 32'h0);
         cycle();
      end
`ifdef FETCH_PERF_EN
      check("perf_stall", perf_stall, 32'd5);
`endif
      bus.imem_req_ready = 1'b1;
      bus.inst_ready     = 1'b1;
      run_accepts("hold_accepts", 4, 20);
`ifdef FETCH_PERF_EN
      check("perf_fetched_min", 32'(perf_fetched >= 32'(n_accepts)), 32'd1);
`endif

      // Access fault on the word at 0x8.
      err_addr = 32'h8;
      do_reset();
      bus.inst_ready = 1'b1;
      run_accepts("fault_accepts", 6, 30);
      check("fault_count", 32'(n_faults), 32'd1);
      err_addr = 32'h1;

      // PC wrap past the top of the address space.
      fb  = fire_log.size();
      acc = n_accepts;
      bus.redirect    = 1'b1;
      bus.redirect_pc = 32'hFFFF_FFFC;
      cycle();
      bus.redirect = 1'b0;
      for (int i = 0; i < 20 && fire_log.size() < fb + 2; i++) cycle();
      check("wrap_addr0", (fire_log.size() > fb) ? fire_log[fb] : 32'hDEAD_BEEF, 32'hFFFF_FFFC);
      check("wrap_addr1", (fire_log.size() > fb + 1) ? fire_log[fb + 1] : 32'hDEAD_BEEF, 32'h0);
      run_accepts("wrap_accepts", acc + 3, 30);

      // Random backpressure, latency and redirects.
      for (int phase = 0; phase < 3; phase++) begin
         lat = int'($urandom_range(3, 1));
         do_reset();
         for (int i = 0; i < 300; i++) begin
            bus.inst_ready     = ($urandom_range(99, 0) < 70);
            bus.imem_req_ready = ($urandom_range(99, 0) < 75);
            bus.redirect       = ($urandom_range(99, 0) < 5);
            bus.redirect_pc    = $urandom;
            cycle();
         end
         bus.redirect       = 1'b0;
         bus.inst_ready     = 1'b1;
         bus.imem_req_ready = 1'b1;
         acc = n_accepts;
         run_accepts("rand_drain", acc + 4, 40);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
